// File: rtl/vrf_read_responder.sv
// Serving end of the VRF read-request protocol: round-robin read arbitration onto one
// single-ported bank, writes take priority, and results return exactly 2 cycles after fire.
module vrf_read_responder #(
   parameter int NUM_PORTS = 4,
   parameter int VS_W      = 5,
   parameter int OFF_W     = 4,
   parameter int DATA_W    = 32,
   parameter int SRC_W     = 2,
   parameter int IDX_W     = 3
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        read_valid,
   output logic [NUM_PORTS-1:0]        read_ready,
   input  logic [NUM_PORTS*VS_W-1:0]   read_vs,
   input  logic [NUM_PORTS*OFF_W-1:0]  read_offset,
   input  logic [NUM_PORTS*SRC_W-1:0]  read_source,
   input  logic [NUM_PORTS*IDX_W-1:0]  read_inst_index,
   output logic [NUM_PORTS-1:0]        result_valid,
   output logic [DATA_W-1:0]           result_data,
   output logic [SRC_W-1:0]            result_source,
   output logic [IDX_W-1:0]            result_inst_index,
   input  logic                        write_valid,
   output logic                        write_ready,
   input  logic [VS_W-1:0]             write_vs,
   input  logic [OFF_W-1:0]            write_offset,
   input  logic [DATA_W-1:0]           write_data,
   input  logic [DATA_W/8-1:0]         write_mask,
   output logic                        sram_ce,
   output logic                        sram_we,
   output logic [VS_W+OFF_W-1:0]       sram_addr,
   output logic [DATA_W-1:0]           sram_wdata,
   output logic [DATA_W/8-1:0]         sram_wmask,
   input  logic [DATA_W-1:0]           sram_rdata
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [PTR_W-1:0] rrPtr;
   logic [PTR_W-1:0] grantIdx;
   logic             grantFound;
   logic             readFire;
   int               candidate;

   logic [VS_W-1:0]  grantVs;
   logic [OFF_W-1:0] grantOffset;
   logic [SRC_W-1:0] grantSource;
   logic [IDX_W-1:0] grantInstIndex;

   logic             s1Valid;
   logic [PTR_W-1:0] s1Port;
   logic [SRC_W-1:0] s1Source;
   logic [IDX_W-1:0] s1InstIndex;

   // Scan upward from the port after the last one served, so each port waits at most NUM_PORTS-1 grants.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = rrPtr;
      candidate  = 0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         candidate = (int'(rrPtr) + i) % NUM_PORTS;
         if (!grantFound && read_valid[candidate]) begin
            grantFound = 1'b1;
            grantIdx   = PTR_W'(candidate);
         end
      end
   end

   assign grantVs        = read_vs[int'(grantIdx)*VS_W +: VS_W];
   assign grantOffset    = read_offset[int'(grantIdx)*OFF_W +: OFF_W];
   assign grantSource    = read_source[int'(grantIdx)*SRC_W +: SRC_W];
   assign grantInstIndex = read_inst_index[int'(grantIdx)*IDX_W +: IDX_W];

   // A pending write owns the bank; the losing reads simply retry next cycle.
   assign readFire    = grantFound && !write_valid;
   assign read_ready  = readFire ? (NUM_PORTS'(1) << grantIdx) : '0;
   assign write_ready = 1'b1;

   assign sram_ce    = write_valid || grantFound;
   assign sram_we    = write_valid;
   assign sram_addr  = write_valid ? {write_vs, write_offset} : {grantVs, grantOffset};
   assign sram_wdata = write_data;
   assign sram_wmask = write_mask;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rrPtr             <= PTR_W'(NUM_PORTS - 1);
         s1Valid           <= 1'b0;
         s1Port            <= '0;
         s1Source          <= '0;
         s1InstIndex       <= '0;
         result_valid      <= '0;
         result_data       <= '0;
         result_source     <= '0;
         result_inst_index <= '0;
      end else begin
         s1Valid <= readFire;
         if (readFire) begin
            rrPtr       <= grantIdx;
            s1Port      <= grantIdx;
            s1Source    <= grantSource;
            s1InstIndex <= grantInstIndex;
         end
         // Bank data for the stage-1 read is present this cycle; capture it with its tags.
         result_valid <= s1Valid ? (NUM_PORTS'(1) << s1Port) : '0;
         if (s1Valid) begin
            result_data       <= sram_rdata;
            result_source     <= s1Source;
            result_inst_index <= s1InstIndex;
         end
      end
   end

endmodule

// File: doc/vrf_read_responder.md
Name: vrf_read_responder

Overview:
- Serving end of the VRF read-request protocol: accepts per-lane read requests from NUM_PORTS requester pipes, arbitrates them round-robin onto one single-ported VRF SRAM bank, and returns read data with a fixed 2-cycle latency.
- The fixed latency matches the requester's 2-stage fire pipeline, so requester data queues capture results without any tag.
- One write port shares the bank and has absolute priority over reads.

Parameters:
- NUM_PORTS, 4, number of read requesters.
- VS_W, 5, vector register index width.
- OFF_W, 4, group offset width inside a register.
- DATA_W, 32, lane data width; write mask is DATA_W/8 bits.
- SRC_W, 2, readSource tag width.
- IDX_W, 3, instructionIndex width.

Ports:
- clock  in  1  Clock.
- reset  in  1  Reset; asynchronous, active-high.
- read_valid  in  NUM_PORTS  Per-port request valid.
- read_ready  out  NUM_PORTS  Per-port grant; fire = valid & ready.
- read_vs  in  NUM_PORTS*VS_W  Per-port register index; port p occupies slice p.
- read_offset  in  NUM_PORTS*OFF_W  Per-port group offset.
- read_source  in  NUM_PORTS*SRC_W  Per-port readSource tag.
- read_inst_index  in  NUM_PORTS*IDX_W  Per-port instructionIndex.
- result_valid  out  NUM_PORTS  One-hot; data for port p is valid this cycle.
- result_data  out  DATA_W  Read data, broadcast to all ports.
- result_source  out  SRC_W  readSource tag of the returning request.
- result_inst_index  out  IDX_W  instructionIndex tag of the returning request.
- write_valid  in  1  Write request.
- write_ready  out  1  Always 1; writes never stall.
- write_vs  in  VS_W  Write register index.
- write_offset  in  OFF_W  Write group offset.
- write_data  in  DATA_W  Write data.
- write_mask  in  DATA_W/8  Byte enables.
- sram_ce  out  1  Bank enable.
- sram_we  out  1  Write enable.
- sram_addr  out  VS_W+OFF_W  Bank address, {vs, offset}.
- sram_wdata  out  DATA_W  Bank write data.
- sram_wmask  out  DATA_W/8  Bank byte mask.
- sram_rdata  in  DATA_W  Bank read data, valid 1 cycle after a read with ce=1, we=0.

Behaviour:
- Reset (asynchronous, active-high):
  - s1_valid, s2_valid, result_valid cleared to 0.
  - rr_ptr set to NUM_PORTS-1, so port 0 has first priority.
  - result_data, result_source, result_inst_index reset to 0.
- Cycle 0, arbitration (combinational):
  - If write_valid: read_ready = 0 and the SRAM performs the write.
    - ce=1, we=1, addr={write_vs, write_offset}, wdata=write_data, wmask=write_mask.
  - Else: grant the first valid port scanning upward from rr_ptr+1, modulo NUM_PORTS.
    - read_ready is one-hot on the granted port.
    - SRAM: ce=1, we=0, addr from the granted port.
  - No valid requests: ce=0, read_ready=0.
  - read_ready never depends on read_valid of other ports beyond arbitration, and is independent of result state.
- rr_ptr updates to the granted index only on a read fire. Writes and idle cycles leave it unchanged.
- Stage 1 (cycle 1):
  - Register s1_valid, s1_port, s1_source, s1_inst_index for the fired read.
  - The SRAM returns sram_rdata this cycle.
- Stage 2 (cycle 2):
  - result_valid[s1_port] = s1_valid.
  - result_data = sram_rdata captured at the end of cycle 1.
  - Tags are copied from stage 1.
  - When no result is valid, result_data and tags hold their last values.
- Latency: exactly 2 cycles from read fire to result_valid. Fully pipelined, one read per cycle, no backpressure on results.
- Read-after-write:
  - A read fired in the cycle after a write to the same address returns the new data.
  - A write in the cycle after a read fire does not affect that read's data.
- Simultaneous write and reads: the write wins; reads retry the next cycle and rr_ptr is unchanged.
- Reset mid-operation: in-flight reads are discarded, and no result_valid pulse follows reset deassertion.
- Widths: sram_addr = VS_W+OFF_W bits, no wrap logic; every address is legal.

Test Plan:
- Write vs=3, offset=2, data=0xDEADBEEF, mask=4'hF, then the next cycle port 1 reads vs=3, offset=2 -> read_ready[1]=1 at cycle t; result_valid=4'b0010 at t+2; result_data=0xDEADBEEF.
- All 4 ports hold valid constantly for 8 cycles after reset -> grants in order 0,1,2,3,0,1,2,3; results one-hot in the same order, each 2 cycles after its grant.
- write_valid and read_valid=4'b0100 in the same cycle -> read_ready=0, sram_we=1; the next cycle port 2 is granted; rr_ptr unchanged by the write cycle.
- Partial write mask=4'b0011, data=0x0000ABCD over stored 0x11223344 -> a subsequent read returns 0x1122ABCD.
- Port 0 fires with source=2, inst_index=5 -> result_source=2 and result_inst_index=5 at fire+2.
- Assert reset one cycle after a read fire -> result_valid stays 0 after release; the first post-reset grant goes to port 0.
